// File: rtl/pio_pkg.sv
// pio_pkg: shared defaults and helpers for the PIO FIFO.
//   WIDTH_DEF   - default data word width
//   DEPTH_DEF   - default entries per half (total storage is twice this)
//   level_width - bit width needed to hold an entry count of 0..2*depth
package pio_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 4;

  function automatic int level_width(input int depth);
    return $clog2(2 * depth) + 1;
  endfunction

endpackage

// File: rtl/pio_fifo.sv
// pio_fifo: first-word-fall-through FIFO between a PIO state machine and
// its producer/consumer. Storage is 2*DEPTH words; join_en selects whether
// the active capacity is DEPTH or 2*DEPTH.
//
// Ports
//   pclk      - divided state-machine clock, all state changes on rising edge
//   reset     - synchronous, active-high
//   join_en   - 0: capacity DEPTH, 1: capacity 2*DEPTH (any change flushes)
//   flush     - discard all entries (error flags are kept)
//   push/din  - producer write strobe and data
//   pull      - consumer read strobe
//   dout      - head entry, combinational; 0 when empty
//   full      - level equals active capacity
//   empty     - level equals 0
//   level     - current entry count
//   clr_err   - clear sticky overflow/underflow
//   overflow  - sticky: a push was dropped because the FIFO was full
//   underflow - sticky: a pull arrived while the FIFO was empty
module pio_fifo
  import pio_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                          pclk,
  input  logic                          reset,
  input  logic                          join_en,
  input  logic                          flush,
  input  logic                          push,
  input  logic [WIDTH-1:0]              din,
  input  logic                          pull,
  output logic [WIDTH-1:0]              dout,
  output logic                          full,
  output logic                          empty,
  output logic [level_width(DEPTH)-1:0] level,
  input  logic                          clr_err,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int SLOTS = 2 * DEPTH;
  localparam int PW    = $clog2(SLOTS);
  localparam int LW    = level_width(DEPTH);

  logic [WIDTH-1:0] mem [SLOTS];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [LW-1:0]    count;
  logic             join_q;
  logic             ovf_flag;
  logic             unf_flag;

  logic [LW-1:0]    cap;
  logic             do_flush;
  logic             wr_ok;
  logic             rd_ok;
  logic             ovf_set;
  logic             unf_set;

  // Pointers wrap at the active capacity rather than at the storage size,
  // so in non-joined mode only the lower half of storage is used.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr,
                                             input logic [LW-1:0] limit);
    logic [LW-1:0] wide;
    wide = {{(LW-PW){1'b0}}, ptr};
    if (wide == limit - 1'b1) return '0;
    return ptr + 1'b1;
  endfunction

  always_comb begin
    cap      = join_q ? LW'(SLOTS) : LW'(DEPTH);
    full     = (count == cap);
    empty    = (count == '0);
    level    = count;
    overflow = ovf_flag;
    underflow = unf_flag;
    // A change of join_en reshapes the buffer, so contents are discarded.
    do_flush = flush | (join_en != join_q);
    // When full, a simultaneous pull frees the head slot for the push.
    wr_ok    = push & (~full | pull);
    rd_ok    = pull & ~empty;
    // Flush overrides both strobes, so they cannot raise errors that cycle.
    ovf_set  = push & full & ~pull & ~do_flush;
    unf_set  = pull & empty & ~do_flush;
    dout     = empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      join_q   <= join_en;
      ovf_flag <= 1'b0;
      unf_flag <= 1'b0;
    end else begin
      join_q   <= join_en;
      // A new error in the same cycle as clr_err keeps the flag set.
      ovf_flag <= (ovf_flag & ~clr_err) | ovf_set;
      unf_flag <= (unf_flag & ~clr_err) | unf_set;
      if (do_flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_ok) wr_ptr <= next_ptr(wr_ptr, cap);
        if (rd_ok) rd_ptr <= next_ptr(rd_ptr, cap);
        count <= count + {{(LW-1){1'b0}}, wr_ok} - {{(LW-1){1'b0}}, rd_ok};
      end
    end
  end

  // Storage has no reset; emptiness is tracked by count and dout is masked.
  always_ff @(posedge pclk) begin
    if (!reset && !do_flush && wr_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: tb/tb_pio_fifo.sv
module tb_pio_fifo;

  logic        pclk = 1'b0;
  logic        reset;
  logic        join_en;
  logic        flush;
  logic        push;
  logic [31:0] din;
  logic        pull;
  logic [31:0] dout;
  logic        full;
  logic        empty;
  logic [3:0]  level;
  logic        clr_err;
  logic        overflow;
  logic        underflow;

  int tests = 0;
  int fails = 0;

  always #5 pclk = ~pclk;

  pio_fifo #(.DEPTH(4), .WIDTH(32)) dut (
    .pclk(pclk), .reset(reset), .join_en(join_en), .flush(flush),
    .push(push), .din(din), .pull(pull), .dout(dout), .full(full),
    .empty(empty), .level(level), .clr_err(clr_err),
    .overflow(overflow), .underflow(underflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes; strobes drop again 1 time unit after the edge.
  task automatic cyc(input logic p, input logic [31:0] d, input logic q);
    push = p;
    din  = d;
    pull = q;
    @(posedge pclk);
    #1;
    push    = 1'b0;
    pull    = 1'b0;
    flush   = 1'b0;
    clr_err = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic flags(input string tag, input logic o, input logic u);
    check({tag, ".overflow"}, 64'(overflow), 64'(o));
    check({tag, ".underflow"}, 64'(underflow), 64'(u));
  endtask

  initial begin
    reset = 1'b1; join_en = 1'b0; flush = 1'b0; push = 1'b0;
    din = '0; pull = 1'b0; clr_err = 1'b0;
    @(posedge pclk); #1;
    reset = 1'b1;
    cyc(0, 0, 0);
    // Reset state
    check("rst.level", 64'(level), 0);
    check("rst.empty", 64'(empty), 1);
    check("rst.full", 64'(full), 0);
    check("rst.dout", 64'(dout), 0);
    flags("rst", 0, 0);

    // Fill to capacity 4
    cyc(1, 32'h11, 0);
    check("fill1.dout", 64'(dout), 64'h11);
    check("fill1.level", 64'(level), 1);
    cyc(1, 32'h22, 0);
    cyc(1, 32'h33, 0);
    check("fill3.full", 64'(full), 0);
    cyc(1, 32'h44, 0);
    check("fill4.level", 64'(level), 4);
    check("fill4.full", 64'(full), 1);
    check("fill4.dout", 64'(dout), 64'h11);
    cyc(1, 32'h55, 0);
    check("ovf.level", 64'(level), 4);
    check("ovf.dout", 64'(dout), 64'h11);
    flags("ovf", 1, 0);

    // Drain
    cyc(0, 0, 1);
    check("drain1.dout", 64'(dout), 64'h22);
    cyc(0, 0, 1);
    check("drain2.dout", 64'(dout), 64'h33);
    cyc(0, 0, 1);
    check("drain3.dout", 64'(dout), 64'h44);
    cyc(0, 0, 1);
    check("drain4.empty", 64'(empty), 1);
    check("drain4.dout", 64'(dout), 0);
    flags("drain4", 1, 0);
    cyc(0, 0, 1);
    check("unf.level", 64'(level), 0);
    flags("unf", 1, 1);
    clr_err = 1'b1;
    cyc(0, 0, 0);
    flags("clr", 0, 0);

    // Simultaneous push/pull while full
    cyc(1, 32'h11, 0);
    cyc(1, 32'h22, 0);
    cyc(1, 32'h33, 0);
    cyc(1, 32'h44, 0);
    cyc(1, 32'h66, 1);
    check("simf.level", 64'(level), 4);
    check("simf.full", 64'(full), 1);
    check("simf.dout", 64'(dout), 64'h22);
    flags("simf", 0, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    check("simf.tail", 64'(dout), 64'h66);
    cyc(0, 0, 1);
    check("simf.empty", 64'(empty), 1);

    // Simultaneous push/pull while empty
    cyc(1, 32'h77, 1);
    check("sime.level", 64'(level), 1);
    check("sime.dout", 64'(dout), 64'h77);
    flags("sime", 0, 1);
    cyc(0, 0, 1);
    check("sime.empty", 64'(empty), 1);
    clr_err = 1'b1;
    cyc(0, 0, 0);

    // Joined mode: capacity 8
    join_en = 1'b1;
    cyc(0, 0, 0);
    check("join.level0", 64'(level), 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 32'(i), 0);
      if (i == 4) check("join4.full", 64'(full), 0);
      if (i == 7) check("join7.full", 64'(full), 0);
    end
    check("join8.full", 64'(full), 1);
    check("join8.level", 64'(level), 8);
    check("join8.dout", 64'(dout), 1);
    flags("join8", 0, 0);
    join_en = 1'b0;
    cyc(0, 0, 0);
    check("unjoin.level", 64'(level), 0);
    check("unjoin.empty", 64'(empty), 1);
    check("unjoin.dout", 64'(dout), 0);

    // Wrap: level held at 2 across 20 push/pull pairs
    cyc(1, 32'hA0, 0);
    cyc(1, 32'hA1, 0);
    for (int k = 0; k < 20; k++) begin
      logic [31:0] exp_head;
      cyc(1, 32'hB0 + 32'(k), 1);
      exp_head = (k == 0) ? 32'hA1 : 32'hB0 + 32'(k - 1);
      check($sformatf("wrap%0d.dout", k), 64'(dout), 64'(exp_head));
      check($sformatf("wrap%0d.level", k), 64'(level), 2);
    end
    flags("wrap", 0, 0);

    // Flush overrides push, keeps flags
    flush = 1'b1;
    cyc(1, 32'hEE, 0);
    check("flush.level", 64'(level), 0);
    check("flush.dout", 64'(dout), 0);
    cyc(1, 32'h1, 0);
    cyc(1, 32'h2, 0);
    cyc(1, 32'h3, 0);
    cyc(1, 32'h4, 0);
    cyc(1, 32'h5, 0);
    flush = 1'b1;
    cyc(0, 0, 0);
    check("flushkeep.level", 64'(level), 0);
    flags("flushkeep", 1, 0);

    // Reset mid-fill at level 3, with a push in the same cycle
    cyc(1, 32'hC1, 0);
    cyc(1, 32'hC2, 0);
    cyc(1, 32'hC3, 0);
    check("midfill.level", 64'(level), 3);
    reset = 1'b1;
    cyc(1, 32'hC4, 0);
    check("midrst.level", 64'(level), 0);
    check("midrst.empty", 64'(empty), 1);
    check("midrst.full", 64'(full), 0);
    check("midrst.dout", 64'(dout), 0);
    flags("midrst", 0, 0);

    // clr_err together with an overflowing push
    cyc(1, 32'hD1, 0);
    cyc(1, 32'hD2, 0);
    cyc(1, 32'hD3, 0);
    cyc(1, 32'hD4, 0);
    clr_err = 1'b1;
    cyc(1, 32'hD5, 0);
    flags("clrwin", 1, 0);
    check("clrwin.dout", 64'(dout), 64'hD1);
    clr_err = 1'b1;
    cyc(0, 0, 0);
    flags("clrdone", 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pio_fifo.md
PIO_FIFO -- requirements
Module: pio_fifo

Interface
REQ-001 The block SHALL take parameter DEPTH, default 4, meaning the entries per half; total storage is 2*DEPTH.
REQ-002 The block SHALL take parameter WIDTH, default 32, meaning the data word width.
REQ-003 Port pclk, input, 1: divided state-machine clock; all state SHALL change only on its rising edge.
REQ-004 Port reset, input, 1: reset, synchronous, active-high.
REQ-005 Port join, input, 1: 0 = capacity DEPTH; 1 = capacity 2*DEPTH.
REQ-006 Port flush, input, 1: discard all entries.
REQ-007 Port push, input, 1: write strobe from the producer.
REQ-008 Port din, input, WIDTH: write data.
REQ-009 Port pull, input, 1: read strobe from the consumer.
REQ-010 Port dout, output, WIDTH: head entry, first-word-fall-through.
REQ-011 Port full, output, 1: level equals capacity.
REQ-012 Port empty, output, 1: level equals 0.
REQ-013 Port level, output, clog2(2*DEPTH)+1: current entry count.
REQ-014 Port clr_err, input, 1: clears the sticky error flags.
REQ-015 Port overflow, output, 1: sticky; a push was dropped.
REQ-016 Port underflow, output, 1: sticky; a pull arrived while empty.

Function
REQ-017 Storage SHALL be a circular buffer of 2*DEPTH words with read and write pointers that wrap at the active capacity.
REQ-018 dout SHALL equal the head entry combinationally from storage, with zero latency; when empty, dout SHALL be 0.
REQ-019 A push accepted at edge N SHALL be visible on dout and level after edge N if the FIFO was empty.
REQ-020 A push while not full SHALL store din at the write pointer and advance the pointer.
REQ-021 A push while full and without a pull SHALL be dropped, SHALL set overflow, and SHALL leave storage unchanged.
REQ-022 A pull while not empty SHALL advance the read pointer.
REQ-023 A pull while empty SHALL set underflow and SHALL change no pointer.
REQ-024 Push and pull together while full SHALL both be accepted, leaving level unchanged and full asserted.
REQ-025 Push and pull together while empty SHALL accept the push, SHALL ignore the pull, and SHALL set underflow; level becomes 1.
REQ-026 Push and pull together otherwise SHALL accept both, leaving level unchanged.
REQ-027 flush SHALL zero the pointers and level on the next edge; it SHALL override push and pull in the same cycle; the error flags SHALL be unaffected.
REQ-028 Any change of join, detected by comparing against its registered copy, SHALL perform a flush in that cycle.
REQ-029 clr_err SHALL clear overflow and underflow; a new error in the same cycle SHALL win, so the flag stays set.
REQ-030 level SHALL never exceed capacity; full and empty SHALL never be asserted together.

Reset
REQ-031 On reset the block SHALL set pointers = 0, level = 0, empty = 1, full = 0, overflow = 0, underflow = 0, and the registered join copy = join.
REQ-032 Reset SHALL take priority over flush, push, pull and clr_err.
REQ-033 Reset mid-operation SHALL discard contents; storage words need not be cleared, but dout SHALL read 0 after reset.

Structure
REQ-034 Shared package pio_pkg SHALL hold the WIDTH default (32), the DEPTH default (4), and the level-width function.
REQ-035 The block SHALL be a single module with no sub-module; two instances serve each state machine, TX feeding pull/din and RX consuming push/dout.

Verification
REQ-036 Fill: with join=0, push 0x11, 0x22, 0x33, 0x44 -> level 4, full=1, dout=0x11; a fifth push of 0x55 -> dropped, overflow=1.
REQ-037 Drain: after the fill, pull four times -> dout sequence 0x11, 0x22, 0x33, 0x44, then empty=1 and dout=0; a fifth pull -> underflow=1.
REQ-038 Simultaneous: when full, push 0x66 with a pull -> level stays 4 and dout becomes 0x22; when empty, push 0x77 with a pull -> level 1, dout=0x77, underflow=1.
REQ-039 Join: with join=1, push 8 words 0x1..0x8 -> full only after the eighth and level=8; toggling join -> level 0 and empty=1 on the next edge.
REQ-040 Wrap: 20 interleaved push/pull pairs with level held at 2 -> data order preserved across pointer wrap, with no flags set.
REQ-041 Reset/flags: reset mid-fill (level 3) -> level 0 and all flags 0; clr_err together with an overflowing push -> overflow remains 1.
